// File: rtl/router_input_port_buffer.sv
// Per-input-port flit FIFO with head-of-line route decode for the 2x2 router.
// The head flit requests its destination output; a matching grant pops it onto a registered crossbar lane.
module router_input_port_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int NUM_OF_OUTS = 2,
    parameter int DEST_WIDTH  = $clog2(NUM_OF_OUTS),
    parameter int DEST_LSB    = 0,
    parameter int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [NUM_OF_OUTS-1:0] out_req,
    input  logic [NUM_OF_OUTS-1:0] out_grant,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [NUM_OF_OUTS-1:0] out_valid,
    output logic [CNT_WIDTH-1:0]   occupancy,
    output logic                   drop_pulse
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] head;
    logic [DEST_WIDTH-1:0] dest;
    logic                  empty;
    logic                  dest_ok;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  deq;

    assign head     = mem[rd_ptr];
    assign dest     = head[DEST_LSB +: DEST_WIDTH];
    assign empty    = (occupancy == '0);
    assign dest_ok  = (32'(dest) < NUM_OF_OUTS);
    assign in_ready = (occupancy != CNT_WIDTH'(DEPTH));
    assign push     = in_valid && in_ready;

    // Request is built only from stored state so the arbiter's grant cannot loop back into it.
    for (genvar i = 0; i < NUM_OF_OUTS; i++) begin : g_req
        assign out_req[i] = !empty && (32'(dest) == i);
    end

    assign pop  = |(out_req & out_grant);
    assign drop = !empty && !dest_ok;
    assign deq  = pop || drop;

    // Storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            out_data   <= '0;
            out_valid  <= '0;
            drop_pulse <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !deq)      occupancy <= occupancy + CNT_WIDTH'(1);
            else if (!push && deq) occupancy <= occupancy - CNT_WIDTH'(1);
            if (pop) out_data <= head;
            out_valid  <= pop ? out_req : '0;
            drop_pulse <= drop;
        end
    end

endmodule

// File: tb/tb_router_input_port_buffer.sv
// Bench for router_input_port_buffer: a 2-output and a 3-output instance share the input link;
// each is checked against a queue-based model of the buffer's rules.
module tb_router_input_port_buffer;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h0;

    logic       a_ready, a_drop;
    logic [1:0] a_req, a_grant, a_valid;
    logic [7:0] a_data;
    logic [2:0] a_occ;

    logic       b_ready, b_drop;
    logic [2:0] b_req, b_grant, b_valid;
    logic [7:0] b_data;
    logic [2:0] b_occ;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    router_input_port_buffer #(.DATA_WIDTH(8), .DEPTH(4), .NUM_OF_OUTS(2)) dut_a (
        .clk(clk), .rst_b(rst_b), .in_data(in_data), .in_valid(in_valid), .in_ready(a_ready),
        .out_req(a_req), .out_grant(a_grant), .out_data(a_data), .out_valid(a_valid),
        .occupancy(a_occ), .drop_pulse(a_drop));

    router_input_port_buffer #(.DATA_WIDTH(8), .DEPTH(4), .NUM_OF_OUTS(3), .DEST_WIDTH(2)) dut_b (
        .clk(clk), .rst_b(rst_b), .in_data(in_data), .in_valid(in_valid), .in_ready(b_ready),
        .out_req(b_req), .out_grant(b_grant), .out_data(b_data), .out_valid(b_valid),
        .occupancy(b_occ), .drop_pulse(b_drop));

    // Reference: a queue of stored flits per instance plus the expected registered outputs.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [2:0] ea_req, eb_req, ea_valid, eb_valid;
    logic [7:0] ea_data, eb_data;
    logic       ea_rdy, eb_rdy, ea_drop, eb_drop;
    int         ea_occ, eb_occ;
    logic [1:0] oa_req;
    logic [2:0] ob_req;
    logic       oa_rdy, ob_rdy;

    function automatic logic [2:0] req_of(input int sz, input logic [7:0] hd, input int n, input int dw);
        int d;
        if (sz == 0) return 3'b000;
        d = int'(hd) % (1 << dw);
        if (d < n) return 3'(1 << d);
        return 3'b000;
    endfunction

    task automatic model_clear();
        qa.delete(); qb.delete();
        ea_data = 8'h0; eb_data = 8'h0; ea_valid = 3'b0; eb_valid = 3'b0;
        ea_drop = 1'b0; eb_drop = 1'b0; ea_occ = 0; eb_occ = 0;
    endtask

    task automatic step(input logic iv, input logic [7:0] id, input logic [1:0] ga, input logic [2:0] gb);
        logic pa, pb, da, db;
        in_valid = iv; in_data = id; a_grant = ga; b_grant = gb;
        ea_rdy = (qa.size() != 4);
        eb_rdy = (qb.size() != 4);
        ea_req = req_of(qa.size(), (qa.size() > 0) ? qa[0] : 8'h0, 2, 1);
        eb_req = req_of(qb.size(), (qb.size() > 0) ? qb[0] : 8'h0, 3, 2);
        #1;
        oa_req = a_req; oa_rdy = a_ready; ob_req = b_req; ob_rdy = b_ready;
        @(posedge clk); #1;
        pa = |(ea_req[1:0] & ga);
        da = (qa.size() > 0) && (ea_req == 3'b0);
        ea_valid = pa ? ea_req : 3'b0;
        if (pa) ea_data = qa[0];
        ea_drop = da;
        if (pa || da) void'(qa.pop_front());
        if (iv && ea_rdy) qa.push_back(id);
        ea_occ = qa.size();
        pb = |(eb_req & gb);
        db = (qb.size() > 0) && (eb_req == 3'b0);
        eb_valid = pb ? eb_req : 3'b0;
        if (pb) eb_data = qb[0];
        eb_drop = db;
        if (pb || db) void'(qb.pop_front());
        if (iv && eb_rdy) qb.push_back(id);
        eb_occ = qb.size();
    endtask

    task automatic do_reset();
        rst_b = 1'b0; in_valid = 1'b0; a_grant = 2'b0; b_grant = 3'b0;
        model_clear();
        @(posedge clk); #1;
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        step(1'b1, 8'h11, 2'b00, 3'b000);
        step(1'b1, 8'h12, 2'b00, 3'b000);
        rst_b = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        #1;
        nchk++; if (a_occ !== 3'd0 || b_occ !== 3'd0) begin nfail++; $display("FAIL rst_async_occ: got %0d/%0d expected 0", a_occ, b_occ); end
        nchk++; if (a_valid !== 2'b00 || a_data !== 8'h00 || a_drop !== 1'b0) begin nfail++; $display("FAIL rst_async_out: got v=%b d=%h dp=%b expected 00/00/0", a_valid, a_data, a_drop); end
        nchk++; if (a_req !== 2'b00) begin nfail++; $display("FAIL rst_req: got %b expected 00", a_req); end
        @(posedge clk); @(posedge clk); #1;
        nchk++; if (a_occ !== 3'd0 || b_occ !== 3'd0) begin nfail++; $display("FAIL rst_no_store: got %0d/%0d expected 0", a_occ, b_occ); end
        rst_b = 1'b1;
        model_clear();
        #1;
        nchk++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin nfail++; $display("FAIL rst_ready: got %b/%b expected 1", a_ready, b_ready); end
        nchk++; if (a_req !== 2'b00 || a_occ !== 3'd0) begin nfail++; $display("FAIL rst_release: got req=%b occ=%0d expected 00/0", a_req, a_occ); end
        in_valid = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        step(1'b1, 8'h01, 2'b00, 3'b000);
        step(1'b0, 8'h00, 2'b10, 3'b000);
        nchk++; if (oa_req !== 2'b10) begin nfail++; $display("FAIL single_req: got %b expected 10", oa_req); end
        nchk++; if (a_valid !== 2'b10 || a_data !== 8'h01) begin nfail++; $display("FAIL single_out: got %b/%h expected 10/01", a_valid, a_data); end
        nchk++; if (a_occ !== 3'd0) begin nfail++; $display("FAIL single_occ: got %0d expected 0", a_occ); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] pushed[4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pushed[i] = 8'($urandom);
            step(1'b1, pushed[i], 2'b00, 3'b000);
        end
        step(1'b1, 8'hAA, 2'b00, 3'b000);
        nchk++; if (oa_rdy !== 1'b0) begin nfail++; $display("FAIL full_ready: got %b expected 0", oa_rdy); end
        nchk++; if (a_occ !== 3'd4) begin nfail++; $display("FAIL full_occ: got %0d expected 4", a_occ); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 2'b11, 3'b000);
            nchk++; if (a_valid !== 2'(1 << pushed[i][0]) || a_data !== pushed[i]) begin
                nfail++; $display("FAIL drain_%0d: got %b/%h expected %b/%h", i, a_valid, a_data, 2'(1 << pushed[i][0]), pushed[i]);
            end
        end
        nchk++; if (a_ready !== 1'b1 || a_occ !== 3'd0) begin nfail++; $display("FAIL drain_end: got rdy=%b occ=%0d expected 1/0", a_ready, a_occ); end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 2'b00, 3'b000);
        step(1'b1, 8'h55, 2'b11, 3'b000);
        nchk++; if (oa_rdy !== 1'b0 || a_occ !== 3'd3) begin nfail++; $display("FAIL full_pushpop: got rdy=%b occ=%0d expected 0/3", oa_rdy, a_occ); end
        step(1'b0, 8'h00, 2'b11, 3'b000);
        step(1'b1, 8'h66, 2'b11, 3'b000);
        nchk++; if (a_occ !== 3'd2 || a_data !== 8'h02) begin nfail++; $display("FAIL pushpop_occ2: got occ=%0d d=%h expected 2/02", a_occ, a_data); end
    endtask

    task automatic test_wrong_grant();
        do_reset();
        step(1'b0, 8'h00, 2'b11, 3'b111);
        nchk++; if (a_valid !== 2'b00 || a_occ !== 3'd0) begin nfail++; $display("FAIL empty_grant: got %b/%0d expected 00/0", a_valid, a_occ); end
        step(1'b1, 8'h00, 2'b00, 3'b000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 2'b10, 3'b000);
            nchk++; if (oa_req !== 2'b01 || a_valid !== 2'b00 || a_occ !== 3'd1) begin
                nfail++; $display("FAIL wrong_grant_%0d: got req=%b v=%b occ=%0d expected 01/00/1", i, oa_req, a_valid, a_occ);
            end
        end
        step(1'b0, 8'h00, 2'b01, 3'b000);
        nchk++; if (a_valid !== 2'b01 || a_data !== 8'h00) begin nfail++; $display("FAIL right_grant: got %b/%h expected 01/00", a_valid, a_data); end
    endtask

    task automatic test_drop();
        do_reset();
        step(1'b1, 8'h03, 2'b00, 3'b000);
        step(1'b1, 8'h02, 2'b00, 3'b000);
        nchk++; if (ob_req !== 3'b000) begin nfail++; $display("FAIL drop_req: got %b expected 000", ob_req); end
        nchk++; if (b_drop !== 1'b1 || b_valid !== 3'b000 || b_occ !== 3'd1) begin nfail++; $display("FAIL drop_pulse: got dp=%b v=%b occ=%0d expected 1/000/1", b_drop, b_valid, b_occ); end
        step(1'b0, 8'h00, 2'b00, 3'b000);
        nchk++; if (ob_req !== 3'b100 || b_drop !== 1'b0) begin nfail++; $display("FAIL drop_next: got req=%b dp=%b expected 100/0", ob_req, b_drop); end
        step(1'b0, 8'h00, 2'b00, 3'b100);
        nchk++; if (b_valid !== 3'b100 || b_data !== 8'h02) begin nfail++; $display("FAIL drop_after: got %b/%h expected 100/02", b_valid, b_data); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step(($urandom % 4) != 0, 8'($urandom), 2'($urandom), 3'($urandom));
            nchk++; if (oa_req !== ea_req[1:0] || ob_req !== eb_req) begin nfail++; $display("FAIL rnd_req @%0d: got %b/%b expected %b/%b", i, oa_req, ob_req, ea_req[1:0], eb_req); end
            nchk++; if (oa_rdy !== ea_rdy || ob_rdy !== eb_rdy) begin nfail++; $display("FAIL rnd_ready @%0d: got %b/%b expected %b/%b", i, oa_rdy, ob_rdy, ea_rdy, eb_rdy); end
            nchk++; if (a_valid !== ea_valid[1:0] || a_data !== ea_data) begin nfail++; $display("FAIL rnd_a_out @%0d: got %b/%h expected %b/%h", i, a_valid, a_data, ea_valid[1:0], ea_data); end
            nchk++; if (b_valid !== eb_valid || b_data !== eb_data) begin nfail++; $display("FAIL rnd_b_out @%0d: got %b/%h expected %b/%h", i, b_valid, b_data, eb_valid, eb_data); end
            nchk++; if (int'(a_occ) != ea_occ || int'(b_occ) != eb_occ) begin nfail++; $display("FAIL rnd_occ @%0d: got %0d/%0d expected %0d/%0d", i, a_occ, b_occ, ea_occ, eb_occ); end
            nchk++; if (a_drop !== ea_drop || b_drop !== eb_drop) begin nfail++; $display("FAIL rnd_drop @%0d: got %b/%b expected %b/%b", i, a_drop, b_drop, ea_drop, eb_drop); end
        end
    endtask

    initial begin
        a_grant = 2'b0;
        b_grant = 3'b0;
        test_reset();
        test_single();
        test_fill_drain();
        test_full_pushpop();
        test_wrong_grant();
        test_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/router_input_port_buffer.md
Name: router_input_port_buffer

Overview:
Per-input-port flit buffer and route decoder for the 2x2 router. It accepts single-flit packets from the link, queues them in a FIFO, and decodes the head flit's destination field into a one-hot request to the output port arbiters. Each output port arbiter returns a grant vector. On a grant for the head flit's destination, the block pops the head flit and drives it registered onto the output crossbar lane.

Parameters:
DATA_WIDTH, 8, flit width in bits; includes the destination field.
DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
NUM_OF_OUTS, 2, number of output ports; width of the request, grant and valid vectors.
DEST_WIDTH, $clog2(NUM_OF_OUTS), width of the destination field.
DEST_LSB, 0, bit position of the destination field's LSB within the flit.
CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width.

Ports:
clk  input  1  single clock, rising edge.
rst_b  input  1  asynchronous active-low reset.
in_data  input  DATA_WIDTH  incoming flit.
in_valid  input  1  in_data valid this cycle.
in_ready  output  1  buffer can accept a flit this cycle.
out_req  output  NUM_OF_OUTS  one-hot request for the head flit's destination port.
out_grant  input  NUM_OF_OUTS  grant from the output arbiters; combinational from out_req.
out_data  output  DATA_WIDTH  registered flit toward the crossbar.
out_valid  output  NUM_OF_OUTS  one-hot; out_data is valid for the indicated output port.
occupancy  output  CNT_WIDTH  number of flits stored.
drop_pulse  output  1  one-cycle pulse when a head flit carrying an out-of-range destination is discarded.

Behaviour:
Reset (async assert, sync deassert handled upstream):
- wr_ptr, rd_ptr and occupancy go to 0.
- out_data goes to 0; out_valid goes to 0; drop_pulse goes to 0.
- in_ready reads 1 once rst_b is high. FIFO storage is not reset.

Push:
- push = in_valid & in_ready. in_ready = (occupancy != DEPTH).
- A full buffer does not accept a flit even if a pop occurs in the same cycle. No write-through.
- in_data written while in_ready=0 is ignored.

Head decode:
- dest = head[DEST_LSB +: DEST_WIDTH].
- When the FIFO is non-empty and dest < NUM_OF_OUTS: out_req = 1 << dest; otherwise out_req = 0.
- out_req depends only on registered state (head entry, occupancy), never on in_valid or out_grant. This avoids a combinational loop through the arbiter.

Pop:
- pop = (out_req & out_grant) != 0.
- Grant bits that do not match out_req are ignored, including grants asserted while the FIFO is empty.
- On pop, on the next edge: out_data <= head flit, out_valid <= out_req, rd_ptr increments.
- With no pop, out_valid <= 0 and out_data holds its value.
- The request stays asserted every cycle until granted; there is no timeout.

Drop:
- When the FIFO is non-empty and dest >= NUM_OF_OUTS, the head is popped that cycle with out_req = 0.
- drop_pulse <= 1 on the next edge; out_valid stays 0.
- This case can only occur when NUM_OF_OUTS is not a power of 2.

Occupancy:
- Increments on push only, decrements on pop/drop only, unchanged when both occur.
- Pointers wrap modulo DEPTH.

Latency:
- Flit pushed at edge N; request visible after edge N; if granted in that cycle, out_valid is high after edge N+1.
- Minimum 2 cycles from in_valid to out_valid. Sustained throughput is 1 flit/cycle while granted every cycle.

Reset mid-operation: all stored flits are lost; outputs return to reset values immediately.

Test Plan:
1. Reset with in_valid=1 -> in_ready=1 after release, out_req=0, out_valid=00, occupancy=0; no flit stored while rst_b=0.
2. Push 0x01 (dest 1), grant 10 immediately -> out_req=10 the cycle after the push, out_valid=10 and out_data=0x01 the following cycle, occupancy returns to 0.
3. Push 4 flits with out_grant=00 -> occupancy=4, in_ready=0; a 5th flit 0xAA is not stored; then grant every cycle -> 4 flits drain in order, one per cycle, then in_ready=1.
4. Full FIFO with push and pop in the same cycle -> push rejected (in_ready=0), occupancy goes 4 to 3; with occupancy=2, simultaneous push and pop keeps occupancy at 2.
5. Head flit 0x00 with out_grant=10 held for 3 cycles -> no pop, out_req stays 01, out_valid=00; out_grant=01 -> pop, out_valid=01.
6. NUM_OF_OUTS=3, DEST_WIDTH=2, head dest=3 -> out_req=000, flit discarded, drop_pulse high for 1 cycle, next flit (dest 2) raises out_req=100.
